// File: rtl/controller_1_pkg.sv
// Shared types and default thresholds for the 3-level DWT lifting controller.
package controller_1_pkg;

    typedef enum logic [2:0] {
        IDLE                 = 3'd0,
        DATA_IN_PHASE1       = 3'd1,
        RESIDUAL_PROCESSING1 = 3'd2,
        DATA_IN_PHASE2       = 3'd3,
        RESIDUAL_PROCESSING2 = 3'd4,
        DATA_IN_PHASE3       = 3'd5,
        RESIDUAL_PROCESSING3 = 3'd6
    } state_t;

    localparam int COUNT_W_DEF  = 5;
    localparam int RES1_END_DEF = 13;
    localparam int IN2_END_DEF  = 16;
    localparam int RES2_END_DEF = 19;
    localparam int IN3_END_DEF  = 21;
    localparam int RES3_END_DEF = 23;

endpackage

// File: rtl/controller_1.sv
// Control FSM sequencing three DWT lifting levels against an external sample counter.
// Optional CONTROLLER_1_STATE_DBG_EN exposes the state encoding on state_dbg.
module controller_1
    import controller_1_pkg::*;
#(
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter int RES1_END = RES1_END_DEF,
    parameter int IN2_END  = IN2_END_DEF,
    parameter int RES2_END = RES2_END_DEF,
    parameter int IN3_END  = IN3_END_DEF,
    parameter int RES3_END = RES3_END_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [COUNT_W-1:0] count,
    output logic               count_enable,
    output logic               data_sel,
    output logic               internal_valid,
    output logic               level_done
`ifdef CONTROLLER_1_STATE_DBG_EN
    ,
    output logic [2:0]         state_dbg
`endif
);

    localparam logic [COUNT_W-1:0] RES1_C = COUNT_W'(RES1_END);
    localparam logic [COUNT_W-1:0] IN2_C  = COUNT_W'(IN2_END);
    localparam logic [COUNT_W-1:0] RES2_C = COUNT_W'(RES2_END);
    localparam logic [COUNT_W-1:0] IN3_C  = COUNT_W'(IN3_END);
    localparam logic [COUNT_W-1:0] RES3_C = COUNT_W'(RES3_END);

    state_t state_r;
    state_t state_next_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a skipped threshold leaves the FSM parked until reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_in) state_next_s = DATA_IN_PHASE1;
                else          state_next_s = IDLE;
            end
            DATA_IN_PHASE1: begin
                if (!valid_in) state_next_s = RESIDUAL_PROCESSING1;
                else           state_next_s = DATA_IN_PHASE1;
            end
            RESIDUAL_PROCESSING1: begin
                if (count == RES1_C) state_next_s = DATA_IN_PHASE2;
                else                 state_next_s = RESIDUAL_PROCESSING1;
            end
            DATA_IN_PHASE2: begin
                if (count == IN2_C) state_next_s = RESIDUAL_PROCESSING2;
                else                state_next_s = DATA_IN_PHASE2;
            end
            RESIDUAL_PROCESSING2: begin
                if (count == RES2_C) state_next_s = DATA_IN_PHASE3;
                else                 state_next_s = RESIDUAL_PROCESSING2;
            end
            DATA_IN_PHASE3: begin
                if (count == IN3_C) state_next_s = RESIDUAL_PROCESSING3;
                else                state_next_s = DATA_IN_PHASE3;
            end
            RESIDUAL_PROCESSING3: begin
                if (count == RES3_C) state_next_s = IDLE;
                else                 state_next_s = RESIDUAL_PROCESSING3;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; level_done is Mealy so it coincides with the level's final count.
    always_comb begin
        count_enable   = 1'b0;
        data_sel       = 1'b0;
        internal_valid = 1'b0;
        level_done     = 1'b0;
        case (state_r)
            IDLE: begin
                count_enable = 1'b0;
            end
            DATA_IN_PHASE1: begin
                count_enable = 1'b1;
            end
            RESIDUAL_PROCESSING1: begin
                count_enable = 1'b1;
                level_done   = (count == RES1_C);
            end
            DATA_IN_PHASE2: begin
                count_enable   = 1'b1;
                data_sel       = 1'b1;
                internal_valid = 1'b1;
            end
            RESIDUAL_PROCESSING2: begin
                count_enable = 1'b1;
                level_done   = (count == RES2_C);
            end
            DATA_IN_PHASE3: begin
                count_enable   = 1'b1;
                data_sel       = 1'b1;
                internal_valid = 1'b1;
            end
            RESIDUAL_PROCESSING3: begin
                count_enable = 1'b1;
                level_done   = (count == RES3_C);
            end
            default: begin
                count_enable = 1'b0;
            end
        endcase
    end

`ifdef CONTROLLER_1_STATE_DBG_EN
    assign state_dbg = state_r;
`endif

endmodule

// File: tb/tb_controller_1.sv
// Randomized self-checking bench for controller_1 using a level/phase reference model.
module tb_controller_1;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [4:0] count;
    logic       count_enable;
    logic       data_sel;
    logic       internal_valid;
    logic       level_done;
`ifdef CONTROLLER_1_STATE_DBG_EN
    logic [2:0] state_dbg;
`endif

    controller_1 dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .count          (count),
        .count_enable   (count_enable),
        .data_sel       (data_sel),
        .internal_valid (internal_valid),
        .level_done     (level_done)
`ifdef CONTROLLER_1_STATE_DBG_EN
        ,
        .state_dbg      (state_dbg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;

    // Reference model: level 0 = idle, 1..3 = active level; m_res marks residual phase.
    int m_lvl = 0;
    bit m_res = 1'b0;
    int res_end [4] = '{0, 13, 19, 23};
    int in_end  [4] = '{0, 0, 16, 21};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input logic r, input logic v, input logic [4:0] c);
        logic e_ce, e_ds, e_ld;
        @(negedge clk);
        reset = r; valid_in = v; count = c;
        #1;
        e_ce = (m_lvl != 0);
        e_ds = (m_lvl >= 2) && !m_res;
        e_ld = (m_lvl != 0) && m_res && (int'(c) == res_end[m_lvl]);
        check("count_enable", {31'd0, count_enable}, {31'd0, e_ce});
        check("data_sel", {31'd0, data_sel}, {31'd0, e_ds});
        check("internal_valid", {31'd0, internal_valid}, {31'd0, e_ds});
        check("level_done", {31'd0, level_done}, {31'd0, e_ld});
`ifdef CONTROLLER_1_STATE_DBG_EN
        check("state_dbg", {29'd0, state_dbg}, (m_lvl == 0) ? 32'd0 : 32'(2 * m_lvl - 1 + int'(m_res)));
`endif
        if (level_done === 1'b1) done_seen++;
        @(posedge clk);
        if (!r) begin
            m_lvl = 0; m_res = 1'b0;
        end else if (m_lvl == 0) begin
            if (v) begin m_lvl = 1; m_res = 1'b0; end
        end else if (!m_res) begin
            if ((m_lvl == 1) ? !v : (int'(c) == in_end[m_lvl])) m_res = 1'b1;
        end else if (int'(c) == res_end[m_lvl]) begin
            m_lvl = (m_lvl == 3) ? 0 : m_lvl + 1;
            m_res = 1'b0;
        end
    endtask

    // Full frame from count 0: valid_in high below vlen, optional counter stalls and glitches.
    task automatic run_frame(input int vlen, input bit stall_en, input bit glitch_en);
        logic [4:0] c;
        logic v;
        bit started;
        int cyc;
        c = 5'd0; started = 1'b0; cyc = 0; done_seen = 0;
        while (cyc < 200 && !(started && m_lvl == 0)) begin
            if (m_lvl == 0)                 v = 1'b1;
            else if (m_lvl == 1 && !m_res)  v = (int'(c) < vlen);
            else if (glitch_en)             v = 1'($urandom_range(0, 1));
            else                            v = 1'b0;
            step(1'b1, v, c);
            if (m_lvl != 0) started = 1'b1;
            if (!stall_en || $urandom_range(0, 3) != 0) c = c + 5'd1;
            cyc++;
        end
        if (!(started && m_lvl == 0)) check("frame_timeout", 32'd1, 32'd0);
        check("level_done_pulses", 32'(done_seen), 32'd3);
        step(1'b1, 1'b0, c);
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; count = 5'd0;
        // Reset held with valid_in high, then release into phase 1.
        step(1'b0, 1'b1, 5'd0);
        step(1'b0, 1'b1, 5'd0);
        step(1'b1, 1'b1, 5'd0);
        step(1'b1, 1'b1, 5'd1);
        step(1'b0, 1'b0, 5'd0);

        // Directed frame: valid_in for counts 0-7, counter advances every cycle.
        run_frame(8, 1'b0, 1'b0);

        // Idle hold with a wandering counter.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'($urandom_range(0, 31)));

        // Threshold skip in residual 1: 12 -> 14 parks the FSM.
        step(1'b1, 1'b1, 5'd0);
        for (int i = 1; i <= 12; i++) step(1'b1, (i < 4) ? 1'b1 : 1'b0, 5'(i));
        step(1'b1, 1'b0, 5'd14);
        step(1'b1, 1'b0, 5'd15);
        step(1'b1, 1'b0, 5'd16);
        step(1'b0, 1'b0, 5'd16);
        step(1'b1, 1'b0, 5'd0);

        // Mid-frame reset in data phase 2 at count 15, then a clean frame.
        for (int i = 0; i <= 15; i++) step(1'b1, (i < 8) ? 1'b1 : 1'b0, 5'(i));
        step(1'b0, 1'b0, 5'd16);
        step(1'b1, 1'b0, 5'd17);
        run_frame(8, 1'b0, 1'b0);

        // valid_in glitches outside phase 1 must not disturb anything.
        run_frame(5, 1'b0, 1'b1);

        // Randomized frames with counter stalls and glitches.
        for (int f = 0; f < 20; f++) run_frame($urandom_range(1, 10), 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controller_1.md
Name: controller_1

Overview:
- Control FSM for a 3-level DWT lifting datapath.
- Sequences three levels. Each level has a data-input phase followed by a residual-processing (pipeline flush) phase.
- Paced by an external 5-bit sample counter that this block enables.
- Drives the datapath input-select mux and the internal-valid strobe, and flags completion of each level.

Parameters:
- COUNT_W, 5: width of count input.
- RES1_END, 13: count value ending residual phase 1.
- IN2_END, 16: count value ending data-input phase 2.
- RES2_END, 19: count value ending residual phase 2.
- IN3_END, 21: count value ending data-input phase 3.
- RES3_END, 23: count value ending residual phase 3.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- valid_in  input  1  external sample valid; high while level-1 input samples stream in.
- count  input  COUNT_W  current value of the external sample counter.
- count_enable  output  1  increment enable for the external counter.
- data_sel  output  1  datapath input mux: 0 = external samples, 1 = internal feedback (approximation coefficients).
- internal_valid  output  1  valid strobe for fed-back samples.
- level_done  output  1  one-cycle pulse at the end of each level.

Behaviour:
- States: IDLE, DATA_IN_PHASE1, RESIDUAL_PROCESSING1, DATA_IN_PHASE2, RESIDUAL_PROCESSING2, DATA_IN_PHASE3, RESIDUAL_PROCESSING3. Encoded in 3 bits.
- Reset (reset==0 at clk edge): state <= IDLE, including mid-operation. Every output is 0 while in IDLE.
- Transitions (registered; evaluated each rising edge):
  - IDLE -> DATA_IN_PHASE1 when valid_in==1; otherwise stay.
  - DATA_IN_PHASE1 -> RESIDUAL_PROCESSING1 when valid_in==0; count is ignored here.
  - RESIDUAL_PROCESSING1 -> DATA_IN_PHASE2 when count==RES1_END.
  - DATA_IN_PHASE2 -> RESIDUAL_PROCESSING2 when count==IN2_END.
  - RESIDUAL_PROCESSING2 -> DATA_IN_PHASE3 when count==RES2_END.
  - DATA_IN_PHASE3 -> RESIDUAL_PROCESSING3 when count==IN3_END.
  - RESIDUAL_PROCESSING3 -> IDLE when count==RES3_END.
- Comparisons are exact equality. If count skips a threshold, the FSM holds in its state until reset. There is no timeout.
- valid_in is ignored in all states except IDLE and DATA_IN_PHASE1.
- Outputs (combinational decode, no added latency):
  - count_enable = 1 in every state except IDLE.
  - data_sel = 1 only in DATA_IN_PHASE2 and DATA_IN_PHASE3.
  - internal_valid = 1 only in DATA_IN_PHASE2 and DATA_IN_PHASE3.
  - level_done (Mealy) = 1 in the single cycle where state is RESIDUAL_PROCESSINGk and count equals its end value (RES1_END, RES2_END, RES3_END). This gives exactly three pulses per frame.
- After returning to IDLE, a new frame starts on the next valid_in==1. The counter is cleared externally; this block does not clear it.

Optional Feature:
- Macro CONTROLLER_1_STATE_DBG_EN.
- When defined: adds output port state_dbg (3 bits) carrying the current state encoding (IDLE = 0, then ascending in the order listed above). Reset value 0.
- When undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Package controller_1_pkg holds:
  - the state enum typedef (3-bit, encodings as above);
  - default threshold localparams matching the parameter defaults.
- No sub-module: a single FSM module with one state register and combinational next-state/output logic.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid_in=1 -> all outputs 0, state IDLE. Release -> DATA_IN_PHASE1 next edge, count_enable=1, data_sel=0.
- Full frame: valid_in=1 for counts 0-7, drop at count 8, counter increments each cycle to 24:
  - count_enable=1 throughout;
  - data_sel=internal_valid=1 only in counts 14-16 and 20-21 windows;
  - level_done pulses at counts 13, 19, 23;
  - IDLE with all outputs 0 after count 23.
- Idle hold: reset released, valid_in=0 for 10 cycles with count varying -> state stays IDLE, all outputs 0.
- Threshold skip: in RESIDUAL_PROCESSING1, count jumps 12->14 -> FSM stays in RESIDUAL_PROCESSING1, no level_done. Apply reset -> IDLE.
- Mid-frame reset: assert reset while in DATA_IN_PHASE2 (count 15) -> next edge IDLE, all outputs 0. Second full frame then behaves identically to the first.
- valid_in glitch: valid_in=1 during RESIDUAL_PROCESSING2 -> no state or output change.
